// File: rtl/trex_pkg.sv
// Shared definitions for the T-Rex game: delegate game-state codes, the dino
// motion FSM encoding and default ballistic parameters.
package trex_pkg;

  localparam logic [1:0] INIT_STATE   = 2'b00;
  localparam logic [1:0] INGAME_STATE = 2'b10;
  localparam logic [1:0] DEAD_STATE   = 2'b01;

  typedef enum logic [1:0] {
    MS_GROUND  = 2'd0,
    MS_RISING  = 2'd1,
    MS_FALLING = 2'd2,
    MS_FROZEN  = 2'd3
  } motion_state_e;

  localparam int DEF_Y_W     = 8;
  localparam int DEF_V0      = 12;
  localparam int DEF_GRAVITY = 1;
  localparam int DEF_MAX_Y   = 100;

  // The unused code 2'b11 behaves exactly like Init.
  function automatic logic is_init_state(input logic [1:0] gs);
    return (gs == INIT_STATE) || (gs == 2'b11);
  endfunction

endpackage

// File: rtl/dino_jump_ctrl.sv
// Vertical-motion controller for the dino: integer ballistic jump advanced on
// frame ticks, frozen while the game is Dead, reset to ground by Init.
module dino_jump_ctrl
  import trex_pkg::*;
#(
  parameter int Y_W     = DEF_Y_W,
  parameter int V0      = DEF_V0,
  parameter int GRAVITY = DEF_GRAVITY,
  parameter int MAX_Y   = DEF_MAX_Y
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     game_state,
  input  logic           jump,
  input  logic           frame_tick,
  output logic [Y_W-1:0] dino_y,
  output logic           airborne,
  output logic           landed
);

  localparam logic [Y_W-1:0]        V0_Y   = Y_W'(V0);
  localparam logic signed [Y_W:0]   V0_V   = (Y_W+1)'(V0);
  localparam logic signed [Y_W:0]   GRAV_V = (Y_W+1)'(GRAVITY);
  localparam logic [Y_W-1:0]        MAX_YY = Y_W'(MAX_Y);
  localparam logic signed [Y_W+1:0] MAX_S  = (Y_W+2)'(MAX_Y);

  motion_state_e         state_q, state_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic signed [Y_W:0]   v_q, v_d;
  logic                  pend_q, pend_d;
  logic                  airborne_q, airborne_d;
  logic                  landed_q, landed_d;

  logic                  gs_init, gs_dead;
  logic signed [Y_W+1:0] s;
  logic signed [Y_W:0]   v_step;
  logic                  s_le0, v_step_le0;

  assign gs_init = is_init_state(game_state);
  assign gs_dead = (game_state == DEAD_STATE);

  // Height is non-negative, so zero-extend it; velocity is sign-extended.
  assign s          = $signed({2'b00, y_q}) + $signed({v_q[Y_W], v_q});
  assign s_le0      = s[Y_W+1] || (s == '0);
  assign v_step     = v_q - GRAV_V;
  assign v_step_le0 = v_step[Y_W] || (v_step == '0);

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    v_d      = v_q;
    landed_d = 1'b0;

    if (gs_init) begin
      state_d = MS_GROUND;
      y_d     = '0;
      v_d     = '0;
    end else if (gs_dead) begin
      state_d = MS_FROZEN;
    end else begin
      unique case (state_q)
        MS_GROUND: begin
          if (frame_tick && (pend_q || jump)) begin
            state_d = MS_RISING;
            y_d     = V0_Y;
            v_d     = V0_V - GRAV_V;
          end else begin
            y_d = '0;
            v_d = '0;
          end
        end
        MS_RISING, MS_FALLING: begin
          if (frame_tick) begin
            if (s_le0) begin
              state_d  = MS_GROUND;
              y_d      = '0;
              v_d      = '0;
              landed_d = 1'b1;
            end else if (s > MAX_S) begin
              state_d = MS_FALLING;
              y_d     = MAX_YY;
              v_d     = '0;
            end else begin
              y_d = s[Y_W-1:0];
              v_d = v_step;
              if (v_step_le0) state_d = MS_FALLING;
            end
          end
        end
        default: ;  // FROZEN is left only through Init
      endcase
    end
  end

  // Jump latch: only armed on the ground, consumed or dropped on every tick.
  always_comb begin
    pend_d = pend_q;
    if (frame_tick || (state_q != MS_GROUND)) pend_d = 1'b0;
    else if (jump && !gs_dead)                 pend_d = 1'b1;
  end

  assign airborne_d = (state_d == MS_RISING) || (state_d == MS_FALLING) ||
                      ((state_d == MS_FROZEN) && (y_d != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MS_GROUND;
      y_q        <= '0;
      v_q        <= '0;
      pend_q     <= 1'b0;
      airborne_q <= 1'b0;
      landed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      v_q        <= v_d;
      pend_q     <= pend_d;
      airborne_q <= airborne_d;
      landed_q   <= landed_d;
    end
  end

  assign dino_y   = y_q;
  assign airborne = airborne_q;
  assign landed   = landed_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Self-checking bench for dino_jump_ctrl: directed trajectory scenarios plus
// randomized stimulus compared against a behavioural height/velocity model.
module tb_dino_jump_ctrl;
  import trex_pkg::*;

  localparam int V0   = 12;
  localparam int G    = 1;
  localparam int MAXY = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] game_state = INIT_STATE;
  logic       jump = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] dino_y, dino_y2;
  logic       airborne, landed, airborne2, landed2;

  always #5 clk = ~clk;

  dino_jump_ctrl dut (
    .clk(clk), .rst(rst), .game_state(game_state), .jump(jump),
    .frame_tick(frame_tick), .dino_y(dino_y), .airborne(airborne), .landed(landed)
  );

  dino_jump_ctrl #(.MAX_Y(40)) dut_low (
    .clk(clk), .rst(rst), .game_state(game_state), .jump(jump),
    .frame_tick(frame_tick), .dino_y(dino_y2), .airborne(airborne2), .landed(landed2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: height, velocity, in-flight and frozen flags.
  int m_h = 0, m_v = 0;
  bit m_air = 0, m_frozen = 0, m_pend = 0, m_landed = 0;

  int traj[25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                   77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
  int traj_low[25] = '{12, 23, 33, 40, 40, 39, 37, 34, 30, 25, 19, 12, 4, 0,
                       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit on_ground, next_pend;
    int s;
    if (rst) begin
      m_h = 0; m_v = 0; m_air = 0; m_frozen = 0; m_pend = 0; m_landed = 0;
      return;
    end
    m_landed  = 0;
    on_ground = !m_air && !m_frozen;
    if (frame_tick || !on_ground)                next_pend = 0;
    else if (jump && game_state != DEAD_STATE)   next_pend = 1;
    else                                         next_pend = m_pend;

    if (game_state == INIT_STATE || game_state == 2'b11) begin
      m_h = 0; m_v = 0; m_air = 0; m_frozen = 0;
    end else if (game_state == DEAD_STATE) begin
      m_frozen = 1;
    end else if (m_frozen) begin
      // stays frozen until Init
    end else if (on_ground) begin
      if (frame_tick && (m_pend || jump)) begin
        m_h = V0; m_v = V0 - G; m_air = 1;
      end
    end else if (frame_tick) begin
      s = m_h + m_v;
      if (s <= 0) begin
        m_h = 0; m_v = 0; m_air = 0; m_landed = 1;
      end else if (s > MAXY) begin
        m_h = MAXY; m_v = 0;
      end else begin
        m_h = s; m_v = m_v - G;
      end
    end
    m_pend = next_pend;
  endtask

  task automatic cycle(input bit r, input logic [1:0] gs, input bit j, input bit t);
    int exp_air;
    rst = r; game_state = gs; jump = j; frame_tick = t;
    @(posedge clk);
    model_step();
    #1;
    exp_air = m_frozen ? int'(m_h != 0) : int'(m_air);
    check("dino_y", int'(dino_y), m_h);
    check("airborne", int'(airborne), exp_air);
    check("landed", int'(landed), int'(m_landed));
  endtask

  // gap idle cycles then one tick cycle, jump held at j throughout
  task automatic tick_after(input logic [1:0] gs, input bit j, input int gap);
    for (int i = 0; i < gap; i++) cycle(0, gs, j, 0);
    cycle(0, gs, j, 1);
  endtask

  initial begin
    // Reset and Init, then a jump three cycles ahead of the first tick.
    cycle(1, INIT_STATE, 0, 0);
    cycle(1, INIT_STATE, 0, 0);
    check("reset_y", int'(dino_y), 0);
    check("reset_airborne", int'(airborne), 0);
    check("reset_landed", int'(landed), 0);
    cycle(0, INIT_STATE, 0, 0);
    cycle(0, INGAME_STATE, 0, 0);
    cycle(0, INGAME_STATE, 1, 0);
    cycle(0, INGAME_STATE, 0, 0);
    cycle(0, INGAME_STATE, 0, 0);
    for (int k = 0; k < 25; k++) begin
      tick_after(INGAME_STATE, 0, (k == 0) ? 0 : 2);
      $display("arc tick %0d: y=%0d y_max40=%0d landed=%0b", k + 1, dino_y, dino_y2, landed);
      check("arc_y", int'(dino_y), traj[k]);
      check("arc_y_max40", int'(dino_y2), traj_low[k]);
      if (k == 13) check("landed_max40", int'(landed2), 1);
      if (k == 24) check("landed_tick25", int'(landed), 1);
    end
    cycle(0, INGAME_STATE, 0, 0);
    check("landed_one_cycle", int'(landed), 0);

    // Jump held through the whole flight: relaunch only after landing.
    for (int k = 0; k < 26; k++) begin
      tick_after(INGAME_STATE, 1, 1);
      $display("held-jump tick %0d: y=%0d landed=%0b", k + 1, dino_y, landed);
      check("held_y", int'(dino_y), (k < 25) ? traj[k] : 12);
    end

    // Dead mid-air freezes the height; Init restarts on the ground.
    cycle(0, INIT_STATE, 0, 0);
    for (int k = 0; k < 6; k++) tick_after(INGAME_STATE, (k == 0), 1);
    check("pre_dead_y", int'(dino_y), 57);
    for (int k = 0; k < 10; k++) begin
      tick_after(DEAD_STATE, k[0], 1);
      $display("dead tick %0d: y=%0d airborne=%0b", k + 1, dino_y, airborne);
      check("frozen_y", int'(dino_y), 57);
      check("frozen_airborne", int'(airborne), 1);
    end
    tick_after(INGAME_STATE, 1, 1);
    check("ingame_keeps_frozen", int'(dino_y), 57);
    cycle(0, INIT_STATE, 0, 0);
    check("restart_y", int'(dino_y), 0);
    check("restart_airborne", int'(airborne), 0);

    // Reset mid-air, then an immediate relaunch.
    for (int k = 0; k < 3; k++) tick_after(INGAME_STATE, (k == 0), 1);
    cycle(1, INGAME_STATE, 0, 1);
    check("rst_mid_air_y", int'(dino_y), 0);
    check("rst_mid_air_landed", int'(landed), 0);
    cycle(0, INGAME_STATE, 1, 1);
    check("relaunch_y", int'(dino_y), 12);

    // Jump with no tick for 50 cycles: takeoff waits for the first tick.
    cycle(0, INIT_STATE, 0, 0);
    for (int k = 0; k < 50; k++) cycle(0, INGAME_STATE, 1, 0);
    check("no_tick_y", int'(dino_y), 0);
    cycle(0, INGAME_STATE, 0, 1);
    check("pending_takeoff_y", int'(dino_y), 12);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [1:0] gs;
      r = int'($urandom_range(0, 99));
      if (r < 80)      gs = INGAME_STATE;
      else if (r < 88) gs = INIT_STATE;
      else if (r < 96) gs = DEAD_STATE;
      else             gs = 2'b11;
      cycle(($urandom_range(0, 199) == 0), gs,
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
